// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access (data first),
// holding a completed fetch in a one-entry buffer while the pipeline is frozen. ARB_PERF_CNT_EN adds wait counters.
module mem_port_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifReq,
  input  logic [31:0] ifAddr,
  input  logic        exMemRead,
  input  logic        exMemWrite,
  input  logic [31:0] exMemAddr,
  input  logic [31:0] exMemWData,
  input  logic [31:0] memRdata,
  output logic        memEn,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  output logic [31:0] instr,
  output logic        instrValid,
  output logic [31:0] loadData,
  output logic        dataDone,
  output logic        pipeStall,
  output logic        pcWrite,
  output logic        ifWrite
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0] fetchWaitCycles,
  output logic [31:0] dataWaitCycles
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} arbStateT;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);

  arbStateT          stateReg, stateNext;
  logic [CNT_W-1:0]  cntReg, cntNext;
  logic              memEnReg, memEnNext;
  logic              memWeReg, memWeNext;
  logic [31:0]       memAddrReg, memAddrNext;
  logic [31:0]       memWDataReg, memWDataNext;
  logic [31:0]       loadDataReg, loadDataNext;
  logic              bufValidReg, bufValidNext;
  logic [31:0]       bufDataReg, bufDataNext;

  logic dataReq;
  logic last;
  logic dataLast;
  logic fetchLast;
  logic fetchDirect;

  assign dataReq   = exMemRead | exMemWrite;
  assign last      = (cntReg == LAST_CNT);
  assign dataLast  = (stateReg == DATA) & last;
  assign fetchLast = (stateReg == FETCH) & last;

  // Gated by rst_n so the freeze is released the instant reset is applied.
  assign pipeStall   = rst_n & dataReq & ~dataLast;
  assign dataDone    = dataLast;
  assign fetchDirect = fetchLast & ~pipeStall;
  assign pcWrite     = fetchDirect | (bufValidReg & ~pipeStall);
  assign ifWrite     = pcWrite;
  assign instrValid  = fetchDirect | bufValidReg;
  assign instr       = bufValidReg ? bufDataReg : (fetchDirect ? memRdata : 32'h0);

  assign memEn    = memEnReg;
  assign memWe    = memWeReg;
  assign memAddr  = memAddrReg;
  assign memWData = memWDataReg;
  assign loadData = loadDataReg;

  always_comb begin
    stateNext    = stateReg;
    cntNext      = cntReg;
    memEnNext    = memEnReg;
    memWeNext    = memWeReg;
    memAddrNext  = memAddrReg;
    memWDataNext = memWDataReg;
    loadDataNext = loadDataReg;
    bufValidNext = bufValidReg;
    bufDataNext  = bufDataReg;

    case (stateReg)
      IDLE: begin
        if (dataReq) begin
          stateNext    = DATA;
          cntNext      = '0;
          memEnNext    = 1'b1;
          memWeNext    = exMemWrite;
          memAddrNext  = exMemAddr;
          memWDataNext = exMemWData;
        end else if (ifReq && !bufValidReg) begin
          stateNext   = FETCH;
          cntNext     = '0;
          memEnNext   = 1'b1;
          memWeNext   = 1'b0;
          memAddrNext = ifAddr;
        end
      end
      FETCH, DATA: begin
        if (last) begin
          stateNext = IDLE;
          cntNext   = '0;
          memEnNext = 1'b0;
          memWeNext = 1'b0;
        end else begin
          cntNext = cntReg + CNT_W'(1);
        end
      end
      default: stateNext = IDLE;
    endcase

    if (dataLast && !memWeReg) loadDataNext = memRdata;

    // A fetch finishing under a freeze parks its word until the pipeline can take it.
    if (fetchLast && pipeStall) begin
      bufValidNext = 1'b1;
      bufDataNext  = memRdata;
    end else if (bufValidReg && pcWrite) begin
      bufValidNext = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg    <= IDLE;
      cntReg      <= '0;
      memEnReg    <= 1'b0;
      memWeReg    <= 1'b0;
      memAddrReg  <= '0;
      memWDataReg <= '0;
      loadDataReg <= '0;
      bufValidReg <= 1'b0;
      bufDataReg  <= '0;
    end else begin
      stateReg    <= stateNext;
      cntReg      <= cntNext;
      memEnReg    <= memEnNext;
      memWeReg    <= memWeNext;
      memAddrReg  <= memAddrNext;
      memWDataReg <= memWDataNext;
      loadDataReg <= loadDataNext;
      bufValidReg <= bufValidNext;
      bufDataReg  <= bufDataNext;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [1:0] waitEvent;
  assign waitEvent = {pipeStall, ifReq & ~pcWrite};

  // Index 0 counts fetch waits, index 1 counts data waits; both saturate.
  for (genvar gi = 0; gi < 2; gi++) begin : genWaitCnt
    logic [31:0] waitCntReg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        waitCntReg <= '0;
      end else if (waitEvent[gi] && (waitCntReg != 32'hFFFF_FFFF)) begin
        waitCntReg <= waitCntReg + 32'd1;
      end
    end
  end

  assign fetchWaitCycles = genWaitCnt[0].waitCntReg;
  assign dataWaitCycles  = genWaitCnt[1].waitCntReg;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter, checked every cycle against a
// transaction-level model (countdown per access, queue for the parked instruction).
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifReq;
  logic [31:0] ifAddr;
  logic        exMemRead;
  logic        exMemWrite;
  logic [31:0] exMemAddr;
  logic [31:0] exMemWData;
  logic [31:0] memRdata;
  logic        memEn;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWData;
  logic [31:0] instr;
  logic        instrValid;
  logic [31:0] loadData;
  logic        dataDone;
  logic        pipeStall;
  logic        pcWrite;
  logic        ifWrite;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] fetchWaitCycles;
  logic [31:0] dataWaitCycles;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(LAT), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifReq(ifReq), .ifAddr(ifAddr),
    .exMemRead(exMemRead), .exMemWrite(exMemWrite),
    .exMemAddr(exMemAddr), .exMemWData(exMemWData),
    .memRdata(memRdata),
    .memEn(memEn), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
    .instr(instr), .instrValid(instrValid),
    .loadData(loadData), .dataDone(dataDone),
    .pipeStall(pipeStall), .pcWrite(pcWrite), .ifWrite(ifWrite)
`ifdef ARB_PERF_CNT_EN
    , .fetchWaitCycles(fetchWaitCycles), .dataWaitCycles(dataWaitCycles)
`endif
  );

  int totalCnt = 0;
  int badCnt   = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalCnt++;
    if (got !== exp) begin
      badCnt++;
      $display("FAIL %s: got=%h want=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: an access is a countdown of remaining cycles; parked fetches live in a queue.
  int          remain;
  bit          kindData;
  bit          kindStore;
  logic [31:0] mAddr;
  logic [31:0] mWData;
  logic [31:0] mLoad;
  logic [31:0] bufQ[$];
  logic [31:0] pc;
  logic [31:0] fwCnt;
  logic [31:0] dwCnt;
  bit          lastDone;

  task automatic modelReset();
    remain = 0; kindData = 0; kindStore = 0;
    mAddr = 0; mWData = 0; mLoad = 0;
    bufQ.delete();
    pc = 0; fwCnt = 0; dwCnt = 0; lastDone = 0;
  endtask

  task automatic checkCycle();
    bit          dReq, fin, eDone, eStall, fetchFin, eDirect, eBuf, ePc;
    logic [31:0] eInstr;
    dReq     = exMemRead | exMemWrite;
    fin      = (remain == 1);
    eDone    = kindData && fin;
    eStall   = dReq && !eDone;
    fetchFin = !kindData && fin;
    eDirect  = fetchFin && !eStall;
    eBuf     = bufQ.size() > 0;
    ePc      = eDirect || (eBuf && !eStall);
    eInstr   = eBuf ? bufQ[0] : (eDirect ? memRdata : 32'h0);

    checkVal("memEn", memEn, remain > 0);
    checkVal("memWe", memWe, (remain > 0) && kindStore);
    checkVal("memAddr", memAddr, mAddr);
    checkVal("memWData", memWData, mWData);
    checkVal("instr", instr, eInstr);
    checkVal("instrValid", instrValid, eDirect || eBuf);
    checkVal("loadData", loadData, mLoad);
    checkVal("dataDone", dataDone, eDone);
    checkVal("pipeStall", pipeStall, eStall);
    checkVal("pcWrite", pcWrite, ePc);
    checkVal("ifWrite", ifWrite, ePc);
`ifdef ARB_PERF_CNT_EN
    checkVal("fetchWaitCycles", fetchWaitCycles, fwCnt);
    checkVal("dataWaitCycles", dataWaitCycles, dwCnt);
    if (ifReq && !ePc && fwCnt != 32'hFFFF_FFFF) fwCnt++;
    if (eStall && dwCnt != 32'hFFFF_FFFF) dwCnt++;
`endif
    lastDone = eDone;

    if (ePc) begin
      pc += 4;
      if (eBuf) void'(bufQ.pop_front());
    end
    if (remain > 0) begin
      if (fin) begin
        if (kindData && !kindStore) mLoad = memRdata;
        if (!kindData && eStall) bufQ.push_back(memRdata);
        remain = 0;
      end else begin
        remain--;
      end
    end else if (dReq) begin
      remain = LAT; kindData = 1; kindStore = exMemWrite;
      mAddr = exMemAddr; mWData = exMemWData;
    end else if (ifReq && !eBuf) begin
      remain = LAT; kindData = 0; kindStore = 0;
      mAddr = ifAddr;
    end
  endtask

  // Entered and left at a falling edge with inputs already driven.
  task automatic cycle();
    ifAddr = pc;
    #1;
    checkCycle();
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit ifr, input logic [31:0] rdata);
    for (int i = 0; i < n; i++) begin
      exMemRead = 0; exMemWrite = 0; ifReq = ifr; memRdata = rdata;
      cycle();
    end
  endtask

  task automatic dataAccess(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                            input bit ifr, input logic [31:0] rdata);
    int n;
    n = 0;
    exMemRead = rd; exMemWrite = wr; exMemAddr = a; exMemWData = d; ifReq = ifr; memRdata = rdata;
    do begin
      cycle();
      n++;
    end while (!lastDone && n < 20);
    if (!lastDone) checkVal("dataTimeout", 32'd0, 32'd1);
    exMemRead = 0; exMemWrite = 0;
  endtask

  task automatic resetChecks();
    checkVal("rst_memEn", memEn, 0);
    checkVal("rst_memWe", memWe, 0);
    checkVal("rst_memAddr", memAddr, 0);
    checkVal("rst_memWData", memWData, 0);
    checkVal("rst_instr", instr, 0);
    checkVal("rst_instrValid", instrValid, 0);
    checkVal("rst_loadData", loadData, 0);
    checkVal("rst_dataDone", dataDone, 0);
    checkVal("rst_pipeStall", pipeStall, 0);
    checkVal("rst_pcWrite", pcWrite, 0);
    checkVal("rst_ifWrite", ifWrite, 0);
`ifdef ARB_PERF_CNT_EN
    checkVal("rst_fetchWaitCycles", fetchWaitCycles, 0);
    checkVal("rst_dataWaitCycles", dataWaitCycles, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    bit pend;
    int kind;
    rst_n = 0;
    ifReq = 1; ifAddr = 0; exMemRead = 1; exMemWrite = 0;
    exMemAddr = 32'h55; exMemWData = 32'h66; memRdata = 32'h77;
    modelReset();
    #2;
    resetChecks();
    @(negedge clk);
    rst_n = 1;
    exMemRead = 0;

    // Back-to-back fetches with a fixed instruction word.
    idle(7, 1, 32'h2008_0005);
    idle(3, 0, 32'h0);

    // Load, then store; the store must leave loadData alone.
    dataAccess(1, 0, 32'h100, 32'h0, 0, 32'hDEAD_BEEF);
    idle(1, 0, 32'h0);
    checkVal("loadDataAfterLoad", loadData, 32'hDEAD_BEEF);
    dataAccess(0, 1, 32'h40, 32'h1234_5678, 0, 32'hCAFE_F00D);
    idle(1, 0, 32'h0);
    checkVal("loadDataAfterStore", loadData, 32'hDEAD_BEEF);

    // Load raised during the first fetch cycle: fetch is parked, then released after the load.
    idle(1, 1, 32'h0);
    dataAccess(1, 0, 32'h200, 32'h0, 1, 32'hAAAA_0001);
    idle(6, 1, 32'hBBBB_0002);
    idle(3, 0, 32'h0);

    // Fetch and load requested together from idle: data goes first.
    dataAccess(1, 0, 32'h300, 32'h0, 1, 32'hCCCC_0003);
    idle(6, 1, 32'hDDDD_0004);
    idle(3, 0, 32'h0);

    // Reset mid-access with the load still requested.
    exMemRead = 1; exMemAddr = 32'h400; ifReq = 0; memRdata = 32'h1111_2222;
    cycle();
    cycle();
    rst_n = 0;
    #1;
    resetChecks();
    @(negedge clk);
    modelReset();
    exMemRead = 0;
    rst_n = 1;
    idle(2, 0, 32'h0);

    // Randomized traffic; data requests are held until they complete.
    pend = 0;
    for (int i = 0; i < 800; i++) begin
      if (!pend && $urandom_range(0, 3) == 0) begin
        pend = 1;
        kind = $urandom_range(0, 2);
        exMemRead  = (kind != 1);
        exMemWrite = (kind != 0);
        exMemAddr  = $urandom;
        exMemWData = $urandom;
      end
      ifReq    = ($urandom_range(0, 3) != 0);
      memRdata = $urandom;
      cycle();
      if (lastDone) begin
        pend = 0;
        exMemRead = 0;
        exMemWrite = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end

endmodule
